// File: rtl/id_ex_elastic_reg_if.sv
// ID/EX boundary bus: decode-side valid/ready input bundle and execute-side output bundle.
// Latency: none; this file only groups wires.
// Backpressure: in_ready and out_ready carry it; flush kills held and incoming bundles.
//
// Signals:
//   in_valid/in_ready, wb_in, mem_in, exe_in, rd1_in, rd2_in, rs1_in, rs2_in, rd_in : decode side
//   flush                                                      : synchronous kill
//   out_valid/out_ready, wb, mem, exe, rd1, rd2, rs1, rs2, rd  : execute side
//   bubble_cnt                                                 : saturating idle-cycle count
// The master modport is the decode/execute environment; the slave modport is the register.
interface id_ex_elastic_reg_if #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int WB_W  = 64,
    parameter int MEM_W = 64,
    parameter int EX_W  = 64,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [WB_W-1:0]   wb_in;
    logic [MEM_W-1:0]  mem_in;
    logic [EX_W-1:0]   exe_in;
    logic [XLEN-1:0]   rd1_in;
    logic [XLEN-1:0]   rd2_in;
    logic [RA_W-1:0]   rs1_in;
    logic [RA_W-1:0]   rs2_in;
    logic [RA_W-1:0]   rd_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [EX_W-1:0]   exe;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output in_valid, wb_in, mem_in, exe_in, rd1_in, rd2_in, rs1_in, rs2_in, rd_in,
        output flush, out_ready,
        input  in_ready, out_valid, wb, mem, exe, rd1, rd2, rs1, rs2, rd, bubble_cnt
    );

    modport slave (
        input  in_valid, wb_in, mem_in, exe_in, rd1_in, rd2_in, rs1_in, rs2_in, rd_in,
        input  flush, out_ready,
        output in_ready, out_valid, wb, mem, exe, rd1, rd2, rs1, rs2, rd, bubble_cnt
    );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer, flush, bubble masking and bubble counter.
// Latency: 1 cycle from accept to out_valid; full throughput when streaming.
// Backpressure: in_ready drops only in SKID state, decoded from the state register alone.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : id_ex_elastic_reg_if slave modport (decode input, execute output, flush, bubble_cnt)
module id_ex_elastic_reg #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int WB_W  = 64,
    parameter int MEM_W = 64,
    parameter int EX_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_elastic_reg_if.slave  bus
);

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  exe;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [RA_W-1:0]  rd;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    bundle_t           main_q, main_d;
    bundle_t           skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic    in_ready;
    logic    out_valid;
    logic    accept;
    logic    consume;
    bundle_t in_bundle;

    assign in_bundle = '{
        wb:  bus.wb_in,
        mem: bus.mem_in,
        exe: bus.exe_in,
        rd1: bus.rd1_in,
        rd2: bus.rd2_in,
        rs1: bus.rs1_in,
        rs2: bus.rs2_in,
        rd:  bus.rd_in
    };

    assign accept  = bus.in_valid & in_ready;
    assign consume = out_valid & bus.out_ready;

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-data logic.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Held and incoming bundles are dropped; contents may stay stale because
            // the control outputs are masked whenever out_valid is low.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_bundle;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (consume && accept) begin
                        main_d = in_bundle;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_bundle;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Counts cycles that start with no valid bundle; sticks at all-ones.
        cnt_d = cnt_q;
        if (!out_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q != ST_SKID);
        out_valid = (state_q != ST_EMPTY);
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.wb         = out_valid ? main_q.wb  : '0;
    assign bus.mem        = out_valid ? main_q.mem : '0;
    assign bus.exe        = out_valid ? main_q.exe : '0;
    assign bus.rd1        = main_q.rd1;
    assign bus.rd2        = main_q.rd2;
    assign bus.rs1        = main_q.rs1;
    assign bus.rs2        = main_q.rs2;
    assign bus.rd         = main_q.rd;
    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed bench for id_ex_elastic_reg: reset, streaming, skid ordering, flush, masking, saturation.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low while offering bundles.
module tb_id_ex_elastic_reg;

    logic clk;
    logic rst_n;
    logic rst2_n;

    int checks;
    int failures;

    id_ex_elastic_reg_if #(.CNT_W(16)) bus ();
    id_ex_elastic_reg_if #(.CNT_W(3))  bus2 ();

    id_ex_elastic_reg #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_elastic_reg #(.CNT_W(3)) dut_small (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.wb_in     = '0;
        bus.mem_in    = '0;
        bus.exe_in    = '0;
        bus.rd1_in    = '0;
        bus.rd2_in    = '0;
        bus.rs1_in    = '0;
        bus.rs2_in    = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.wb_in     = 64'hDEAD_BEEF_0123_4567;
        bus.mem_in    = 64'hFFFF_0000_FFFF_0000;
        bus.exe_in    = 64'h1234_5678_9ABC_DEF0;
        bus.rd1_in    = 64'hCAFE;
        bus.rd2_in    = 64'hF00D;
        bus.rs1_in    = 5'd7;
        bus.rs2_in    = 5'd9;
        bus.rd_in     = 5'd31;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready);
        end
        checks++;
        if ({bus.wb, bus.mem, bus.exe} !== '0) begin
            failures++; $display("FAIL reset_ctrl got=%h/%h/%h exp=0", bus.wb, bus.mem, bus.exe);
        end
        checks++;
        if (bus.rd1 !== 64'd0 || bus.rd !== 5'd0) begin
            failures++; $display("FAIL reset_data got rd1=%h rd=%0d exp=0", bus.rd1, bus.rd);
        end
        checks++;
        if (bus.bubble_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_bubble got=%0d exp=0", bus.bubble_cnt);
        end
        drive_idle();
        rst_n = 1'b1;
        step();
        step();
        step();
        checks++;
        if (bus.bubble_cnt !== 16'd3) begin
            failures++; $display("FAIL idle_bubble got=%0d exp=3", bus.bubble_cnt);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.rd1_in = 64'(i);
            bus.rd_in  = 5'(i + 10);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.rd1 !== 64'(i) || bus.rd !== 5'(i + 10)) begin
                failures++;
                $display("FAIL stream_%0d got v=%0b rd1=%0d rd=%0d exp v=1 rd1=%0d rd=%0d",
                         i, bus.out_valid, bus.rd1, bus.rd, i, i + 10);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++; $display("FAIL stream_ready_%0d got=%0b exp=1", i, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL stream_drain got=%0b exp=0", bus.out_valid);
        end
        drive_idle();
    endtask

    task automatic test_skid_order();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rd1_in    = 64'hA;
        step();
        checks++;
        if (bus.rd1 !== 64'hA || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL skid_accept_a got rd1=%h rdy=%0b exp rd1=a rdy=1", bus.rd1, bus.in_ready);
        end
        bus.rd1_in = 64'hB;
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.rd1 !== 64'hA) begin
            failures++; $display("FAIL skid_full got rdy=%0b rd1=%h exp rdy=0 rd1=a", bus.in_ready, bus.rd1);
        end
        bus.in_valid  = 1'b0;
        bus.rd1_in    = 64'hEE;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rd1 !== 64'hB || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL skid_second got v=%0b rd1=%h rdy=%0b exp v=1 rd1=b rdy=1",
                                 bus.out_valid, bus.rd1, bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL skid_drain got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        drive_idle();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.wb_in     = 64'h11;
        bus.rd1_in    = 64'hC;
        step();
        bus.wb_in  = 64'h22;
        bus.rd1_in = 64'hD;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_setup got rdy=%0b exp=0", bus.in_ready);
        end
        bus.flush  = 1'b1;
        bus.wb_in  = 64'h33;
        bus.rd1_in = 64'hE;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.wb, bus.mem, bus.exe} !== '0) begin
            failures++; $display("FAIL flush_kill got v=%0b rdy=%0b wb=%h exp v=0 rdy=1 wb=0",
                                 bus.out_valid, bus.in_ready, bus.wb);
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.wb !== 64'd0) begin
                failures++; $display("FAIL flush_ghost_%0d got v=%0b wb=%h exp v=0 wb=0", i, bus.out_valid, bus.wb);
            end
        end
        drive_idle();
    endtask

    task automatic test_mask();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.wb_in     = 64'hFF;
        bus.mem_in    = 64'h5A;
        bus.exe_in    = 64'hA5;
        bus.rd1_in    = 64'h55;
        step();
        checks++;
        if (bus.wb !== 64'hFF || bus.mem !== 64'h5A || bus.exe !== 64'hA5) begin
            failures++; $display("FAIL mask_live got %h/%h/%h exp ff/5a/a5", bus.wb, bus.mem, bus.exe);
        end
        bus.in_valid = 1'b0;
        bus.wb_in    = 64'h0;
        step();
        checks++;
        if ({bus.wb, bus.mem, bus.exe} !== '0) begin
            failures++; $display("FAIL mask_idle got %h/%h/%h exp 0", bus.wb, bus.mem, bus.exe);
        end
        checks++;
        if (bus.rd1 !== 64'h55) begin
            failures++; $display("FAIL mask_held_rd1 got=%h exp=55", bus.rd1);
        end
        drive_idle();
    endtask

    task automatic test_bubble_sat();
        rst2_n = 1'b0;
        step();
        checks++;
        if (bus2.bubble_cnt !== 3'd0) begin
            failures++; $display("FAIL sat_reset got=%0d exp=0", bus2.bubble_cnt);
        end
        rst2_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (bus2.bubble_cnt !== 3'((i > 7) ? 7 : i)) begin
                failures++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", i, bus2.bubble_cnt, (i > 7) ? 7 : i);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        drive_idle();
        bus2.in_valid  = 1'b0;
        bus2.wb_in     = '0;
        bus2.mem_in    = '0;
        bus2.exe_in    = '0;
        bus2.rd1_in    = '0;
        bus2.rd2_in    = '0;
        bus2.rs1_in    = '0;
        bus2.rs2_in    = '0;
        bus2.rd_in     = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b0;

        test_reset();
        test_stream();
        test_skid_order();
        test_flush();
        test_mask();
        test_bubble_sat();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_elastic_reg.md
Name: id_ex_elastic_reg

Overview:
- Parametrised ID/EX pipeline boundary register for the RV64 pipeline.
- Carries WB/MEM/EX control bundles, two register-read operands and the rs1/rs2/rd indices from decode to execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble-masked control outputs and a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 64, width of rd1/rd2 operand data
- RA_W, 5, register index width
- WB_W, 64, width of WB control bundle
- MEM_W, 64, width of MEM control bundle
- EX_W, 64, width of EX control bundle
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents a valid instruction bundle
- in_ready  out  1  register can accept a bundle this cycle
- wb_in  in  WB_W  WB control from decode
- mem_in  in  MEM_W  MEM control from decode
- exe_in  in  EX_W  EX control from decode
- rd1_in  in  XLEN  operand 1 from register file
- rd2_in  in  XLEN  operand 2 from register file
- rs1_in  in  RA_W  source index 1
- rs2_in  in  RA_W  source index 2
- rd_in  in  RA_W  destination index
- flush  in  1  synchronous kill of all held and incoming bundles (branch/exception)
- out_valid  out  1  execute-side bundle valid
- out_ready  in  1  execute stage consumes bundle this cycle
- wb  out  WB_W  WB control; 0 when out_valid=0
- mem  out  MEM_W  MEM control; 0 when out_valid=0
- exe  out  EX_W  EX control; 0 when out_valid=0
- rd1  out  XLEN  operand 1 (held, not masked)
- rd2  out  XLEN  operand 2 (held, not masked)
- rs1  out  RA_W  source index 1 (held)
- rs2  out  RA_W  source index 2 (held)
- rd  out  RA_W  destination index (held)
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=EMPTY.
  - main and skid entries cleared to 0.
  - bubble_cnt=0; in_ready=1; out_valid=0; all outputs 0.
- Storage:
  - main entry drives the outputs.
  - skid entry holds one extra bundle.
  - Bundle = {wb, mem, exe, rd1, rd2, rs1, rs2, rd}.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Consume occurs when out_valid & out_ready.
- Outputs:
  - in_ready = (state != SKID); decoded from state register only, no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Transitions (evaluated only when flush=0):
  - EMPTY: accept -> main<=in, FULL; else stay.
  - FULL, consume & accept: main<=in, stay FULL (1 bundle/cycle streaming).
  - FULL, consume & !accept: EMPTY.
  - FULL, !consume & accept: skid<=in, SKID.
  - FULL, !consume & !accept: hold.
  - SKID: no accept possible. consume -> main<=skid, FULL; else hold.
- Latency: 1 cycle from accept to out_valid when empty or streaming; order always preserved (FIFO).
- Flush (highest priority, synchronous):
  - Next state EMPTY; any same-cycle accept is discarded.
  - A consume in the flush cycle still completes; the downstream sampled it.
  - Entry contents need not be cleared; masking covers the control bundles.
- Bubble masking: when out_valid=0, wb/mem/exe outputs are forced to 0 combinationally so the EX stage never sees stale control.
- bubble_cnt:
  - Increments by 1 on each clock edge where out_valid=0 before the edge.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset mid-operation: immediate clear regardless of state; any skid content is lost.
- No X propagation: all registers are reset; outputs are defined from reset.

Test Plan:
- Reset with garbage inputs, in_valid=1 -> out_valid=0, in_ready=1, wb/mem/exe=0, bubble_cnt=0 while rst_n=0.
- Stream bundles rd1=1,2,3,4 with out_ready=1 -> same values appear on rd1 one cycle after each accept; in_ready stays 1; no drops.
- Accept A (rd1=0xA), then out_ready=0 while offering B (rd1=0xB) -> in_ready=0 next cycle; raise out_ready -> A then B are output in order, then in_ready=1.
- In SKID state, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, wb/mem/exe=0; neither held bundle nor incoming bundle appears later.
- Accept bundle with wb_in=0xFF, consume it, leave idle -> wb=0 while rd1 still shows the last value.
- CNT_W=3, idle 10 cycles after reset -> bubble_cnt reaches 7 and holds; no wrap to 0.
